plot_arbiter: RTL

Shares the single VGA pixel-write port between several sprite/background drawing FSMs (duck movement, crosshair, HUD/score, background clear). Each requester posts a filled rectangle (origin, size, colour) with a level request. The arbiter grants requesters round-robin, scans the granted rectangle one pixel per clock onto the VGA adapter write port, and returns a one-cycle done pulse, which serves as the requester's doneDrawing handshake.

---
 rtl/plot_arbiter_pkg.sv | 19 +
 rtl/rr_picker.sv | 39 +++
 rtl/plot_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/plot_arbiter_pkg.sv
// Shared definitions for the pixel-write arbiter: FSM state encoding,
// visible screen bounds and default field widths of the VGA adapter.
package plot_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_S_W = 5;
  localparam int DEF_C_W = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req        : level requests, one bit per requester
//   last       : index of the most recently served requester
//   winner_oh  : one-hot winner (all zero when req == 0)
//   winner_idx : binary index of the winner (0 when req == 0)
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  winner_oh,
  output logic [IDX_W-1:0] winner_idx
);

  int               j;
  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest
  // requesting index (highest priority) is the final assignment.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    j          = 0;
    idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j   = (int'(last) + k) % NREQ;
      idx = IDX_W'(j);
      if (req[idx]) begin
        winner_oh      = '0;
        winner_oh[idx] = 1'b1;
        winner_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the single VGA pixel-write port between NREQ rectangle-drawing
// requesters. A winner is chosen round-robin in IDLE, its rectangle is
// latched and scanned one pixel per clock, then a one-cycle done pulse is
// returned to it.
//   clk, reset          : clock, asynchronous active-high reset
//   req                 : level request per requester, held until done
//   rect_x/y/w/h/c      : packed per-requester rectangle fields
//   grant               : one-hot, high while that rectangle is scanned
//   done                : one-cycle completion pulse
//   busy                : FSM not in IDLE
//   vga_x/y/colour/plot : pixel write port of the VGA adapter
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int X_W  = DEF_X_W,
  parameter int Y_W  = DEF_Y_W,
  parameter int S_W  = DEF_S_W,
  parameter int C_W  = DEF_C_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*X_W-1:0] rect_x,
  input  logic [NREQ*Y_W-1:0] rect_y,
  input  logic [NREQ*S_W-1:0] rect_w,
  input  logic [NREQ*S_W-1:0] rect_h,
  input  logic [NREQ*C_W-1:0] rect_c,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [C_W-1:0]    vga_colour,
  output logic              vga_plot
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t state, state_nxt;

  logic [IDX_W-1:0] last;
  logic [NREQ-1:0]  win_oh;
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;

  logic [X_W-1:0] xs [NREQ];
  logic [Y_W-1:0] ys [NREQ];
  logic [S_W-1:0] ws [NREQ];
  logic [S_W-1:0] hs [NREQ];
  logic [C_W-1:0] cs [NREQ];

  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [S_W-1:0] w0, h0;
  logic [C_W-1:0] c0;
  logic [S_W-1:0] cx, cy, cx_nxt, cy_nxt;
  logic [X_W-1:0] px_nxt;
  logic [Y_W-1:0] py_nxt;
  logic           pick_zero, last_col, last_pix;

  for (genvar i = 0; i < NREQ; i++) begin : g_fields
    assign xs[i] = rect_x[i*X_W +: X_W];
    assign ys[i] = rect_y[i*Y_W +: Y_W];
    assign ws[i] = rect_w[i*S_W +: S_W];
    assign hs[i] = rect_h[i*S_W +: S_W];
    assign cs[i] = rect_c[i*C_W +: C_W];
  end

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req        (req),
    .last       (last),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx)
  );

  function automatic logic on_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
    return (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);
  endfunction

  assign pick_zero = (ws[pick_idx] == '0) || (hs[pick_idx] == '0);

  // Raster walk: cx runs fastest, wraps at the rectangle width.
  assign last_col = (cx == w0 - 1'b1);
  assign last_pix = last_col && (cy == h0 - 1'b1);
  assign cx_nxt   = last_col ? '0 : cx + 1'b1;
  assign cy_nxt   = last_col ? cy + 1'b1 : cy;
  assign px_nxt   = x0 + X_W'(cx_nxt);
  assign py_nxt   = y0 + Y_W'(cy_nxt);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (|req) state_nxt = pick_zero ? ST_FINISH : ST_SCAN;
      ST_SCAN:   if (last_pix) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Control and pixel-port registers. The vga_* registers are loaded with
  // the next pixel on the same edge the counters advance, so the pixel at
  // (x0,y0) is visible in the first SCAN cycle and values hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last       <= IDX_W'(NREQ - 1);
      win_oh     <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            last   <= pick_idx;
            win_oh <= pick_oh;
            cx     <= '0;
            cy     <= '0;
            if (!pick_zero) begin
              vga_x      <= xs[pick_idx];
              vga_y      <= ys[pick_idx];
              vga_colour <= cs[pick_idx];
              vga_plot   <= on_screen(xs[pick_idx], ys[pick_idx]);
            end
          end
        end
        ST_SCAN: begin
          cx <= cx_nxt;
          cy <= cy_nxt;
          if (last_pix) begin
            vga_plot <= 1'b0;
          end else begin
            vga_x    <= px_nxt;
            vga_y    <= py_nxt;
            vga_plot <= on_screen(px_nxt, py_nxt);
          end
        end
        default: vga_plot <= 1'b0;
      endcase
    end
  end

  // Rectangle latch: captured only at grant, ignored for the rest of the scan.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && (|req)) begin
      x0 <= xs[pick_idx];
      y0 <= ys[pick_idx];
      w0 <= ws[pick_idx];
      h0 <= hs[pick_idx];
      c0 <= cs[pick_idx];
    end
  end

  assign grant = (state == ST_SCAN)   ? win_oh : '0;
  assign done  = (state == ST_FINISH) ? win_oh : '0;
  assign busy  = (state != ST_IDLE);

endmodule
